// File: rtl/boss_ctrl.sv
// boss_ctrl: stage-3 boss sequencer (entry descent, patrol, hurt, dying, dead).
// Ports: clk, rst_n, state[3:0], tick, hit -> boss_x/y[8:0], boss_state/hp[3:0], boss_fire, boss_dead.
module boss_ctrl #(
    parameter logic [3:0] STAGE3      = 4'd6,
    parameter logic [8:0] X_MIN       = 9'd0,
    parameter logic [8:0] X_MAX       = 9'd300,
    parameter logic [8:0] START_X     = 9'd150,
    parameter logic [8:0] START_Y     = 9'd20,
    parameter logic [3:0] HP_INIT     = 4'd8,
    parameter int         ANIM_DIV    = 8,
    parameter int         FIRE_PERIOD = 60,
    parameter int         HURT_TICKS  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] state,
    input  logic       tick,
    input  logic       hit,
    output logic [8:0] boss_x,
    output logic [8:0] boss_y,
    output logic [3:0] boss_state,
    output logic [3:0] boss_hp,
    output logic       boss_fire,
    output logic       boss_dead
);

    localparam int AW = $clog2(ANIM_DIV + 1);
    localparam int FW = $clog2(FIRE_PERIOD + 1);
    localparam int HW = $clog2(HURT_TICKS + 1);

    localparam logic [8:0] DEAD_Y = 9'd220;

    localparam logic [AW-1:0] ANIM_LAST = AW'(ANIM_DIV - 1);
    localparam logic [FW-1:0] FIRE_LAST = FW'(FIRE_PERIOD - 1);
    localparam logic [HW-1:0] HURT_LAST = HW'(HURT_TICKS - 1);

    typedef enum logic [2:0] {
        IDLE, ENTER, PATROL, HURT, DYING, DEAD
    } fsm_t;

    fsm_t          fsm_q;
    logic [8:0]    x_q, y_q;
    logic [3:0]    bs_q, bs_save_q, hp_q;
    logic          fire_q, dead_q;
    logic          dir_right_q;
    logic [AW-1:0] anim_q;
    logic [FW-1:0] firec_q;
    logic [HW-1:0] hurt_q;

    assign boss_x     = x_q;
    assign boss_y     = y_q;
    assign boss_state = bs_q;
    assign boss_hp    = hp_q;
    assign boss_fire  = fire_q;
    assign boss_dead  = dead_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= IDLE;
            x_q         <= START_X;
            y_q         <= '0;
            bs_q        <= '0;
            bs_save_q   <= '0;
            hp_q        <= HP_INIT;
            fire_q      <= 1'b0;
            dead_q      <= 1'b0;
            dir_right_q <= 1'b1;
            anim_q      <= '0;
            firec_q     <= '0;
            hurt_q      <= '0;
        end else if (state != STAGE3) begin
            // leaving stage 3 aborts everything back to the reset picture
            fsm_q       <= IDLE;
            x_q         <= START_X;
            y_q         <= '0;
            bs_q        <= '0;
            bs_save_q   <= '0;
            hp_q        <= HP_INIT;
            fire_q      <= 1'b0;
            dead_q      <= 1'b0;
            dir_right_q <= 1'b1;
            anim_q      <= '0;
            firec_q     <= '0;
            hurt_q      <= '0;
        end else begin
            fire_q <= 1'b0;
            unique case (fsm_q)
                IDLE: begin
                    fsm_q <= ENTER;
                    bs_q  <= 4'd1;
                end
                ENTER: begin
                    if (tick) begin
                        y_q <= y_q + 9'd1;
                        if (y_q + 9'd1 == START_Y) begin
                            fsm_q   <= PATROL;
                            anim_q  <= '0;
                            firec_q <= '0;
                        end
                    end
                end
                PATROL: begin
                    // a hit pre-empts the tick: no move, no anim, no fire
                    if (hit) begin
                        hp_q      <= hp_q - 4'd1;
                        bs_save_q <= bs_q;
                        hurt_q    <= '0;
                        if (hp_q == 4'd1) begin
                            fsm_q <= DYING;
                            bs_q  <= 4'd4;
                        end else begin
                            fsm_q <= HURT;
                            bs_q  <= 4'd3;
                        end
                    end else if (tick) begin
                        if (dir_right_q) begin
                            if (x_q == X_MAX) begin
                                dir_right_q <= 1'b0;
                                x_q         <= X_MAX - 9'd1;
                            end else begin
                                x_q <= x_q + 9'd1;
                            end
                        end else begin
                            if (x_q == X_MIN) begin
                                dir_right_q <= 1'b1;
                                x_q         <= X_MIN + 9'd1;
                            end else begin
                                x_q <= x_q - 9'd1;
                            end
                        end
                        if (anim_q == ANIM_LAST) begin
                            anim_q <= '0;
                            bs_q   <= (bs_q == 4'd1) ? 4'd2 : 4'd1;
                        end else begin
                            anim_q <= anim_q + 1'b1;
                        end
                        if (firec_q == FIRE_LAST) begin
                            firec_q <= '0;
                            fire_q  <= 1'b1;
                        end else begin
                            firec_q <= firec_q + 1'b1;
                        end
                    end
                end
                HURT: begin
                    if (tick) begin
                        if (hurt_q == HURT_LAST) begin
                            fsm_q <= PATROL;
                            bs_q  <= bs_save_q;
                        end else begin
                            hurt_q <= hurt_q + 1'b1;
                        end
                    end
                end
                DYING: begin
                    if (tick) begin
                        y_q <= y_q + 9'd1;
                        if (y_q + 9'd1 == DEAD_Y) begin
                            fsm_q  <= DEAD;
                            dead_q <= 1'b1;
                            bs_q   <= 4'd0;
                        end
                    end
                end
                DEAD: begin
                    dead_q <= 1'b1;
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_boss_ctrl.sv
// tb_boss_ctrl: directed bench for boss_ctrl with hand-computed expectations.
// Drives state/tick/hit and checks every output through one check task.
module tb_boss_ctrl;

    logic       clk;
    logic       rst_n;
    logic [3:0] state;
    logic       tick;
    logic       hit;
    logic [8:0] boss_x;
    logic [8:0] boss_y;
    logic [3:0] boss_state;
    logic [3:0] boss_hp;
    logic       boss_fire;
    logic       boss_dead;

    int n_checks = 0;
    int n_errors = 0;
    int fire_cnt = 0;

    boss_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .state      (state),
        .tick       (tick),
        .hit        (hit),
        .boss_x     (boss_x),
        .boss_y     (boss_y),
        .boss_state (boss_state),
        .boss_hp    (boss_hp),
        .boss_fire  (boss_fire),
        .boss_dead  (boss_dead)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // one clock with the given tick/hit, sampled 1 ns after the edge
    task automatic step(input logic t, input logic h);
        tick = t;
        hit  = h;
        @(posedge clk);
        #1;
        tick = 1'b0;
        hit  = 1'b0;
        if (boss_fire) fire_cnt++;
    endtask

    // tick clock followed by an idle clock, so a stretched fire shows up
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0);
            step(1'b0, 1'b0);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_x"}, int'(boss_x), 150);
        check({tag, "_y"}, int'(boss_y), 0);
        check({tag, "_bs"}, int'(boss_state), 0);
        check({tag, "_hp"}, int'(boss_hp), 8);
        check({tag, "_fire"}, int'(boss_fire), 0);
        check({tag, "_dead"}, int'(boss_dead), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        state = 4'd0;
        tick  = 1'b0;
        hit   = 1'b0;
        #12;
        check_reset_vals("rst");
        rst_n = 1'b1;
        step(1'b0, 1'b0);
        check("idle_bs", int'(boss_state), 0);

        // entry descent
        state = 4'd6;
        step(1'b0, 1'b0);
        check("enter_y0", int'(boss_y), 0);
        check("enter_bs", int'(boss_state), 1);
        step(1'b0, 1'b1);
        check("enter_hit_hp", int'(boss_hp), 8);
        ticks(1);
        check("enter_y1", int'(boss_y), 1);
        ticks(18);
        check("enter_y19", int'(boss_y), 19);
        ticks(1);
        check("enter_y20", int'(boss_y), 20);
        check("enter_x", int'(boss_x), 150);
        check("enter_bs20", int'(boss_state), 1);

        // patrol, no hits
        fire_cnt = 0;
        ticks(8);
        check("pat_x8", int'(boss_x), 158);
        check("pat_bs8", int'(boss_state), 2);
        ticks(51);
        check("pat_fire59", fire_cnt, 0);
        step(1'b1, 1'b0);
        check("pat_fire60", int'(boss_fire), 1);
        check("pat_x60", int'(boss_x), 210);
        step(1'b0, 1'b0);
        check("pat_fire_w", int'(boss_fire), 0);
        ticks(90);
        check("pat_x150", int'(boss_x), 300);
        check("pat_fcnt", fire_cnt, 2);
        check("pat_bs150", int'(boss_state), 1);
        ticks(1);
        check("pat_x151", int'(boss_x), 299);

        // single hit, second hit ignored while hurt
        step(1'b0, 1'b1);
        check("hurt_hp", int'(boss_hp), 7);
        check("hurt_bs", int'(boss_state), 3);
        check("hurt_x", int'(boss_x), 299);
        step(1'b0, 1'b1);
        check("hurt_hp2", int'(boss_hp), 7);
        ticks(15);
        check("hurt_bs15", int'(boss_state), 3);
        check("hurt_x15", int'(boss_x), 299);
        ticks(1);
        check("hurt_bs16", int'(boss_state), 1);
        ticks(1);
        check("resume_x", int'(boss_x), 298);
        check("resume_bs", int'(boss_state), 2);

        // hit + tick at a fire wrap
        fire_cnt = 0;
        ticks(27);
        check("wrap_x", int'(boss_x), 271);
        check("wrap_bs", int'(boss_state), 1);
        step(1'b1, 1'b1);
        check("ht_hp", int'(boss_hp), 6);
        check("ht_fire", int'(boss_fire), 0);
        check("ht_x", int'(boss_x), 271);
        check("ht_bs", int'(boss_state), 3);
        ticks(16);
        check("ht_bs_back", int'(boss_state), 1);
        check("ht_fcnt", fire_cnt, 0);
        step(1'b1, 1'b0);
        check("late_fire", int'(boss_fire), 1);
        check("late_x", int'(boss_x), 270);

        // remaining hits down to zero
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1);
            ticks(16);
        end
        check("kill_hp1", int'(boss_hp), 1);
        step(1'b0, 1'b1);
        check("dying_hp", int'(boss_hp), 0);
        check("dying_bs", int'(boss_state), 4);
        check("dying_y", int'(boss_y), 20);
        step(1'b0, 1'b1);
        check("dying_hp2", int'(boss_hp), 0);
        ticks(199);
        check("dying_y219", int'(boss_y), 219);
        check("dying_dead", int'(boss_dead), 0);
        ticks(1);
        check("dead_y", int'(boss_y), 220);
        check("dead_flag", int'(boss_dead), 1);
        check("dead_bs", int'(boss_state), 0);
        step(1'b0, 1'b1);
        check("dead_hp", int'(boss_hp), 0);
        ticks(3);
        check("dead_hold", int'(boss_dead), 1);
        check("dead_yh", int'(boss_y), 220);

        // abort on leaving stage 3
        state = 4'd8;
        step(1'b0, 1'b0);
        check_reset_vals("abort");

        // async reset mid-hurt
        state = 4'd6;
        step(1'b0, 1'b0);
        ticks(20);
        ticks(5);
        check("re_x", int'(boss_x), 155);
        step(1'b0, 1'b1);
        check("re_hp", int'(boss_hp), 7);
        ticks(3);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("arst");
        #3;
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
